// File: rtl/tl_top.sv
// -----------------------------------------------------------------------------
// tl_top -- self-contained TileLink-UL demonstration system.
//
// An L1 master stub (l1_stub) issues one PutFullData followed by one Get to
// address 0x10 after reset. The requests pass through a zero-latency
// interconnect (xbar) to an L2 slave stub (l2_stub) backed by a 1024-word
// memory. The L1 stub raises done when the sequence ends, and raises pass if
// both responses were the ones it expected.
//
// Ports (tl_top):
//   clk    in  1  system clock, rising edge
//   rst_n  in  1  synchronous active-low reset
// There are no functional outputs. The system is observed through the
// l1_stub A/D signals, l1_stub.done, l1_stub.pass and l2_stub.mem.
//
// Optional feature:
//   TL_TRACE_EN  when defined, the L1 stub prints every A/D handshake and
//                prints PASS or FAIL when it enters DONE.
//
// Width macros default to the values of the shared tl_params.vh set.
// -----------------------------------------------------------------------------
`ifndef TL_AW
`define TL_AW 32
`endif
`ifndef TL_DW
`define TL_DW 32
`endif
`ifndef TL_SW
`define TL_SW 4
`endif
`ifndef TL_OPW
`define TL_OPW 3
`endif
`ifndef TL_SZW
`define TL_SZW 2
`endif

// L1 master stub: fixed PutFullData / Get sequence to address 0x10.
module tl_l1_stub #(
    parameter int ADDR_W = `TL_AW,
    parameter int DATA_W = `TL_DW,
    parameter int SRC_W  = `TL_SW,
    parameter int OP_W   = `TL_OPW,
    parameter int SZ_W   = `TL_SZW
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                a_valid_o,
    input  logic                a_ready_i,
    output logic [OP_W-1:0]     a_opcode_o,
    output logic [SZ_W-1:0]     a_size_o,
    output logic [DATA_W/8-1:0] a_mask_o,
    output logic [ADDR_W-1:0]   a_address_o,
    output logic [SRC_W-1:0]    a_source_o,
    output logic [DATA_W-1:0]   a_data_o,
    input  logic                d_valid_i,
    output logic                d_ready_o,
    input  logic [OP_W-1:0]     d_opcode_i,
    input  logic [DATA_W-1:0]   d_data_i,
    input  logic [SRC_W-1:0]    d_source_i,
    input  logic                d_denied_i,
    output logic                done_o,
    output logic                pass_o
);
    localparam logic [OP_W-1:0]   OP_PUT     = OP_W'(0);
    localparam logic [OP_W-1:0]   OP_GET     = OP_W'(4);
    localparam logic [OP_W-1:0]   D_ACK      = OP_W'(0);
    localparam logic [OP_W-1:0]   D_ACKDATA  = OP_W'(1);
    localparam logic [ADDR_W-1:0] TARGET     = ADDR_W'(32'h10);
    localparam logic [DATA_W-1:0] PATTERN    = DATA_W'(32'hDEADBEEF);
    localparam logic [SRC_W-1:0]  SRC_PUT    = SRC_W'(1);
    localparam logic [SRC_W-1:0]  SRC_GET    = SRC_W'(2);
    localparam int                SZ         = $clog2(DATA_W / 8);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PUT_REQ  = 3'd1,
        PUT_RESP = 3'd2,
        GET_REQ  = 3'd3,
        GET_RESP = 3'd4,
        DONE     = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic                put_ok_q, put_ok_d;
    logic                get_ok_q, get_ok_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    // Named channel signals, kept as plain nets so they can be observed and
    // overridden from outside; the ports are thin aliases of these.
    logic                a_valid;
    logic                a_ready;
    logic [OP_W-1:0]     a_opcode;
    logic [SZ_W-1:0]     a_size;
    logic [DATA_W/8-1:0] a_mask;
    logic [ADDR_W-1:0]   a_address;
    logic [SRC_W-1:0]    a_source;
    logic [DATA_W-1:0]   a_data;
    logic                d_valid;
    logic                d_ready;
    logic [OP_W-1:0]     d_opcode;
    logic [DATA_W-1:0]   d_data;
    logic [SRC_W-1:0]    d_source;
    logic                d_denied;
    logic                done;
    logic                pass;

    assign a_ready  = a_ready_i;
    assign d_valid  = d_valid_i;
    assign d_opcode = d_opcode_i;
    assign d_data   = d_data_i;
    assign d_source = d_source_i;
    assign d_denied = d_denied_i;
    assign a_size   = SZ_W'(SZ);
    assign a_mask   = '1;

    // Channel outputs depend only on the state, so the A payload is stable
    // for as long as a request is stalled.
    always_comb begin
        a_valid   = 1'b0;
        a_opcode  = OP_PUT;
        a_address = '0;
        a_source  = '0;
        a_data    = '0;
        d_ready   = 1'b0;
        case (state_q)
            PUT_REQ: begin
                a_valid   = 1'b1;
                a_opcode  = OP_PUT;
                a_address = TARGET;
                a_source  = SRC_PUT;
                a_data    = PATTERN;
            end
            GET_REQ: begin
                a_valid   = 1'b1;
                a_opcode  = OP_GET;
                a_address = TARGET;
                a_source  = SRC_GET;
            end
            PUT_RESP, GET_RESP: d_ready = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        put_ok_d = put_ok_q;
        get_ok_d = get_ok_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE:     state_d = PUT_REQ;
            PUT_REQ:  if (a_valid && a_ready) state_d = PUT_RESP;
            PUT_RESP: begin
                if (d_valid && d_ready) begin
                    put_ok_d = (d_opcode == D_ACK) && (d_source == SRC_PUT) && !d_denied;
                    state_d  = GET_REQ;
                end
            end
            GET_REQ:  if (a_valid && a_ready) state_d = GET_RESP;
            GET_RESP: begin
                if (d_valid && d_ready) begin
                    get_ok_d = (d_opcode == D_ACKDATA) && (d_source == SRC_GET) && !d_denied;
                    rdata_d  = d_data;
                    state_d  = DONE;
                end
            end
            default:  state_d = DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            put_ok_q <= 1'b0;
            get_ok_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            put_ok_q <= put_ok_d;
            get_ok_q <= get_ok_d;
            rdata_q  <= rdata_d;
        end
    end

    assign done = (state_q == DONE);
    assign pass = done && put_ok_q && get_ok_q && (rdata_q == PATTERN);

    assign a_valid_o   = a_valid;
    assign a_opcode_o  = a_opcode;
    assign a_size_o    = a_size;
    assign a_mask_o    = a_mask;
    assign a_address_o = a_address;
    assign a_source_o  = a_source;
    assign a_data_o    = a_data;
    assign d_ready_o   = d_ready;
    assign done_o      = done;
    assign pass_o      = pass;

`ifdef TL_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (a_valid && a_ready)
                $display("%0t L1 A op=%0d addr=0x%0h src=%0d data=0x%0h",
                         $time, a_opcode, a_address, a_source, a_data);
            if (d_valid && d_ready)
                $display("%0t L1 D op=%0d src=%0d denied=%0d data=0x%0h",
                         $time, d_opcode, d_source, d_denied, d_data);
            if (state_q != DONE && state_d == DONE)
                $display("%0t L1 %s", $time,
                         (put_ok_q && get_ok_d && rdata_d == PATTERN) ? "PASS" : "FAIL");
        end
    end
`endif
endmodule

// Pass-through interconnect: wires only, no added latency.
module tl_xbar #(
    parameter int ADDR_W = `TL_AW,
    parameter int DATA_W = `TL_DW,
    parameter int SRC_W  = `TL_SW,
    parameter int OP_W   = `TL_OPW,
    parameter int SZ_W   = `TL_SZW
) (
    input  logic                m_a_valid_i,
    output logic                m_a_ready_o,
    input  logic [OP_W-1:0]     m_a_opcode_i,
    input  logic [SZ_W-1:0]     m_a_size_i,
    input  logic [DATA_W/8-1:0] m_a_mask_i,
    input  logic [ADDR_W-1:0]   m_a_address_i,
    input  logic [SRC_W-1:0]    m_a_source_i,
    input  logic [DATA_W-1:0]   m_a_data_i,
    output logic                m_d_valid_o,
    input  logic                m_d_ready_i,
    output logic [OP_W-1:0]     m_d_opcode_o,
    output logic [DATA_W-1:0]   m_d_data_o,
    output logic [SRC_W-1:0]    m_d_source_o,
    output logic                m_d_denied_o,
    output logic                s_a_valid_o,
    input  logic                s_a_ready_i,
    output logic [OP_W-1:0]     s_a_opcode_o,
    output logic [SZ_W-1:0]     s_a_size_o,
    output logic [DATA_W/8-1:0] s_a_mask_o,
    output logic [ADDR_W-1:0]   s_a_address_o,
    output logic [SRC_W-1:0]    s_a_source_o,
    output logic [DATA_W-1:0]   s_a_data_o,
    input  logic                s_d_valid_i,
    output logic                s_d_ready_o,
    input  logic [OP_W-1:0]     s_d_opcode_i,
    input  logic [DATA_W-1:0]   s_d_data_i,
    input  logic [SRC_W-1:0]    s_d_source_i,
    input  logic                s_d_denied_i
);
    assign s_a_valid_o   = m_a_valid_i;
    assign m_a_ready_o   = s_a_ready_i;
    assign s_a_opcode_o  = m_a_opcode_i;
    assign s_a_size_o    = m_a_size_i;
    assign s_a_mask_o    = m_a_mask_i;
    assign s_a_address_o = m_a_address_i;
    assign s_a_source_o  = m_a_source_i;
    assign s_a_data_o    = m_a_data_i;
    assign m_d_valid_o   = s_d_valid_i;
    assign s_d_ready_o   = m_d_ready_i;
    assign m_d_opcode_o  = s_d_opcode_i;
    assign m_d_data_o    = s_d_data_i;
    assign m_d_source_o  = s_d_source_i;
    assign m_d_denied_o  = s_d_denied_i;
endmodule

// L2 slave stub: one outstanding request, 1024-word memory, 1-cycle response.
module tl_l2_stub #(
    parameter int ADDR_W = `TL_AW,
    parameter int DATA_W = `TL_DW,
    parameter int SRC_W  = `TL_SW,
    parameter int OP_W   = `TL_OPW,
    parameter int SZ_W   = `TL_SZW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_valid_i,
    output logic                a_ready_o,
    input  logic [OP_W-1:0]     a_opcode_i,
    input  logic [SZ_W-1:0]     a_size_i,
    input  logic [DATA_W/8-1:0] a_mask_i,
    input  logic [ADDR_W-1:0]   a_address_i,
    input  logic [SRC_W-1:0]    a_source_i,
    input  logic [DATA_W-1:0]   a_data_i,
    output logic                d_valid_o,
    input  logic                d_ready_i,
    output logic [OP_W-1:0]     d_opcode_o,
    output logic [DATA_W-1:0]   d_data_o,
    output logic [SRC_W-1:0]    d_source_o,
    output logic                d_denied_o
);
    localparam logic [OP_W-1:0] OP_PUT    = OP_W'(0);
    localparam logic [OP_W-1:0] OP_GET    = OP_W'(4);
    localparam logic [OP_W-1:0] D_ACK     = OP_W'(0);
    localparam logic [OP_W-1:0] D_ACKDATA = OP_W'(1);
    localparam int              SZ        = $clog2(DATA_W / 8);

    // Not reset: contents survive a system reset.
    reg [DATA_W-1:0] mem [0:1023];

    logic              d_valid_q, d_valid_d;
    logic [OP_W-1:0]   d_opcode_q, d_opcode_d;
    logic [DATA_W-1:0] d_data_q, d_data_d;
    logic [SRC_W-1:0]  d_source_q, d_source_d;
    logic              d_denied_q, d_denied_d;

    logic       a_fire, d_fire;
    logic [9:0] idx;
    logic       out_of_range, malformed, is_put, is_get, reject, wr_en;

    assign a_ready_o    = !d_valid_q;
    assign a_fire       = a_valid_i && a_ready_o;
    assign d_fire       = d_valid_q && d_ready_i;
    assign idx          = a_address_i[SZ+9:SZ];
    assign out_of_range = |a_address_i[ADDR_W-1:SZ+10];
    // Only aligned full-word accesses are meaningful to this memory.
    assign malformed    = (a_size_i != SZ_W'(SZ)) || (a_mask_i != '1) ||
                          (a_address_i[SZ-1:0] != '0);
    assign is_put       = (a_opcode_i == OP_PUT);
    assign is_get       = (a_opcode_i == OP_GET);
    assign reject       = out_of_range || malformed || !(is_put || is_get);
    // Gated by rst_n so a request still on the wires at a reset edge
    // cannot modify memory.
    assign wr_en        = rst_n && a_fire && is_put && !reject;

    always_ff @(posedge clk) begin
        if (wr_en) mem[idx] <= a_data_i;
    end

    always_comb begin
        d_valid_d  = d_valid_q;
        d_opcode_d = d_opcode_q;
        d_data_d   = d_data_q;
        d_source_d = d_source_q;
        d_denied_d = d_denied_q;
        if (d_fire) d_valid_d = 1'b0;
        // a_ready = !d_valid, so a new request never overlaps a pending one.
        if (a_fire) begin
            d_valid_d  = 1'b1;
            d_source_d = a_source_i;
            d_opcode_d = is_get ? D_ACKDATA : D_ACK;
            d_denied_d = reject;
            d_data_d   = (is_get && !reject) ? mem[idx] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_valid_q  <= 1'b0;
            d_opcode_q <= '0;
            d_data_q   <= '0;
            d_source_q <= '0;
            d_denied_q <= 1'b0;
        end else begin
            d_valid_q  <= d_valid_d;
            d_opcode_q <= d_opcode_d;
            d_data_q   <= d_data_d;
            d_source_q <= d_source_d;
            d_denied_q <= d_denied_d;
        end
    end

    assign d_valid_o  = d_valid_q;
    assign d_opcode_o = d_opcode_q;
    assign d_data_o   = d_data_q;
    assign d_source_o = d_source_q;
    assign d_denied_o = d_denied_q;
endmodule

module tl_top (
    input logic clk,
    input logic rst_n
);
    localparam int AW  = `TL_AW;
    localparam int DW  = `TL_DW;
    localparam int SW  = `TL_SW;
    localparam int OPW = `TL_OPW;
    localparam int SZW = `TL_SZW;

    logic            m_a_valid, m_a_ready, m_d_valid, m_d_ready, m_d_denied;
    logic [OPW-1:0]  m_a_opcode, m_d_opcode;
    logic [SZW-1:0]  m_a_size;
    logic [DW/8-1:0] m_a_mask;
    logic [AW-1:0]   m_a_address;
    logic [SW-1:0]   m_a_source, m_d_source;
    logic [DW-1:0]   m_a_data, m_d_data;

    logic            s_a_valid, s_a_ready, s_d_valid, s_d_ready, s_d_denied;
    logic [OPW-1:0]  s_a_opcode, s_d_opcode;
    logic [SZW-1:0]  s_a_size;
    logic [DW/8-1:0] s_a_mask;
    logic [AW-1:0]   s_a_address;
    logic [SW-1:0]   s_a_source, s_d_source;
    logic [DW-1:0]   s_a_data, s_d_data;

    logic            done, pass;

    tl_l1_stub l1_stub (
        .clk(clk), .rst_n(rst_n),
        .a_valid_o(m_a_valid), .a_ready_i(m_a_ready), .a_opcode_o(m_a_opcode),
        .a_size_o(m_a_size), .a_mask_o(m_a_mask), .a_address_o(m_a_address),
        .a_source_o(m_a_source), .a_data_o(m_a_data),
        .d_valid_i(m_d_valid), .d_ready_o(m_d_ready), .d_opcode_i(m_d_opcode),
        .d_data_i(m_d_data), .d_source_i(m_d_source), .d_denied_i(m_d_denied),
        .done_o(done), .pass_o(pass)
    );

    tl_xbar xbar (
        .m_a_valid_i(m_a_valid), .m_a_ready_o(m_a_ready), .m_a_opcode_i(m_a_opcode),
        .m_a_size_i(m_a_size), .m_a_mask_i(m_a_mask), .m_a_address_i(m_a_address),
        .m_a_source_i(m_a_source), .m_a_data_i(m_a_data),
        .m_d_valid_o(m_d_valid), .m_d_ready_i(m_d_ready), .m_d_opcode_o(m_d_opcode),
        .m_d_data_o(m_d_data), .m_d_source_o(m_d_source), .m_d_denied_o(m_d_denied),
        .s_a_valid_o(s_a_valid), .s_a_ready_i(s_a_ready), .s_a_opcode_o(s_a_opcode),
        .s_a_size_o(s_a_size), .s_a_mask_o(s_a_mask), .s_a_address_o(s_a_address),
        .s_a_source_o(s_a_source), .s_a_data_o(s_a_data),
        .s_d_valid_i(s_d_valid), .s_d_ready_o(s_d_ready), .s_d_opcode_i(s_d_opcode),
        .s_d_data_i(s_d_data), .s_d_source_i(s_d_source), .s_d_denied_i(s_d_denied)
    );

    tl_l2_stub l2_stub (
        .clk(clk), .rst_n(rst_n),
        .a_valid_i(s_a_valid), .a_ready_o(s_a_ready), .a_opcode_i(s_a_opcode),
        .a_size_i(s_a_size), .a_mask_i(s_a_mask), .a_address_i(s_a_address),
        .a_source_i(s_a_source), .a_data_i(s_a_data),
        .d_valid_o(s_d_valid), .d_ready_i(s_d_ready), .d_opcode_o(s_d_opcode),
        .d_data_o(s_d_data), .d_source_o(s_d_source), .d_denied_o(s_d_denied)
    );
endmodule

// File: tb/tb_tl_top.sv
// -----------------------------------------------------------------------------
// tb_tl_top -- self-checking bench for tl_top.
// A table of scenarios (memory preload, optional corner action, expected
// pass/mem results) is run in a loop. A monitor checks every A request
// against the fixed sequence and predicts each D response from a reference
// memory; predictions are queued at the A handshake and compared at the
// D handshake.
// -----------------------------------------------------------------------------
module tb_tl_top;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tl_top dut (.clk(clk), .rst_n(rst_n));

    localparam int S_IDLE = 0, S_PUT_REQ = 1, S_PUT_RESP = 2, S_GET_REQ = 3,
                   S_GET_RESP = 4, S_DONE = 5;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  src;
        logic        den;
        logic [31:0] data;
    } rsp_t;
    rsp_t sb[$];

    typedef struct {
        logic [31:0] pre4;
        logic [31:0] fill;
        bit          force_addr;
        bit          hold_dready;
        bit          mid_rst;
        bit          exp_pass;
        logic [31:0] exp4;
    } scen_t;
    scen_t tbl [5];

    logic [31:0] mdl [0:1023];
    logic [31:0] exp_put_addr = 32'h10;
    int a_idx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        rsp_t e;
        logic [31:0] addr;
        if (!rst_n) begin
            sb.delete();
            a_idx = 0;
        end else begin
            if (dut.l1_stub.d_valid && dut.l1_stub.d_ready) begin
                if (sb.size() == 0) begin
                    chk("d_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("d_opcode", 32'(dut.l1_stub.d_opcode), 32'(e.op));
                    chk("d_source", 32'(dut.l1_stub.d_source), 32'(e.src));
                    chk("d_denied", 32'(dut.l1_stub.d_denied), 32'(e.den));
                    chk("d_data",   dut.l1_stub.d_data, e.data);
                end
            end
            if (dut.l1_stub.a_valid && dut.l1_stub.a_ready) begin
                addr = dut.l1_stub.a_address;
                if (a_idx == 0) begin
                    chk("a0_opcode", 32'(dut.l1_stub.a_opcode), 32'd0);
                    chk("a0_address", addr, exp_put_addr);
                    chk("a0_source", 32'(dut.l1_stub.a_source), 32'd1);
                    chk("a0_data", dut.l1_stub.a_data, 32'hDEADBEEF);
                end else if (a_idx == 1) begin
                    chk("a1_opcode", 32'(dut.l1_stub.a_opcode), 32'd4);
                    chk("a1_address", addr, 32'h10);
                    chk("a1_source", 32'(dut.l1_stub.a_source), 32'd2);
                end else begin
                    chk("a_extra", 32'(a_idx), 32'd1);
                end
                a_idx++;
                e.src  = dut.l1_stub.a_source;
                e.data = 32'd0;
                if (dut.l1_stub.a_opcode == 3'd0) begin
                    e.op  = 3'd0;
                    e.den = (addr[31:12] != 20'd0);
                    if (!e.den) mdl[addr[11:2]] = dut.l1_stub.a_data;
                end else if (dut.l1_stub.a_opcode == 3'd4) begin
                    e.op  = 3'd1;
                    e.den = (addr[31:12] != 20'd0);
                    if (!e.den) e.data = mdl[addr[11:2]];
                end else begin
                    e.op  = 3'd0;
                    e.den = 1'b1;
                end
                sb.push_back(e);
            end
        end
    end

    task automatic wait_state(input int s, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (int'(dut.l1_stub.state_q) == s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int cyc;
        int bad;
        // pre4, fill, force_addr, hold_dready, mid_rst, exp_pass, exp4
        tbl[0] = '{32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
        tbl[1] = '{32'h12345678, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
        tbl[2] = '{32'h0BADF00D, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0BADF00D};
        tbl[3] = '{32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
        tbl[4] = '{32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF};

        for (int t = 0; t < 5; t++) begin
            rst_n = 1'b0;
            for (int i = 0; i < 1024; i++) begin
                dut.l2_stub.mem[i] <= tbl[t].fill;
                mdl[i] = tbl[t].fill;
            end
            dut.l2_stub.mem[4] <= tbl[t].pre4;
            mdl[4] = tbl[t].pre4;
            exp_put_addr = tbl[t].force_addr ? 32'h1010 : 32'h10;
            repeat (5) @(posedge clk);
            @(negedge clk);
            chk("rst_state",    32'(dut.l1_stub.state_q), S_IDLE);
            chk("rst_a_valid",  32'(dut.l1_stub.a_valid), 32'd0);
            chk("rst_d_ready",  32'(dut.l1_stub.d_ready), 32'd0);
            chk("rst_done",     32'(dut.l1_stub.done), 32'd0);
            chk("rst_pass",     32'(dut.l1_stub.pass), 32'd0);
            chk("rst_d_valid",  32'(dut.l1_stub.d_valid), 32'd0);
            chk("rst_d_opcode", 32'(dut.l1_stub.d_opcode), 32'd0);
            chk("rst_d_data",   dut.l1_stub.d_data, 32'd0);
            chk("rst_d_source", 32'(dut.l1_stub.d_source), 32'd0);
            chk("rst_d_denied", 32'(dut.l1_stub.d_denied), 32'd0);
            @(posedge clk); #1;
            rst_n = 1'b1;

            if (tbl[t].force_addr) begin
                wait_state(S_PUT_REQ, ok);
                chk("wait_put_req", 32'(ok), 32'd1);
                force dut.l1_stub.a_address = 32'h1010;
                @(posedge clk); #1;
                release dut.l1_stub.a_address;
            end
            if (tbl[t].hold_dready) begin
                wait_state(S_PUT_RESP, ok);
                chk("wait_put_resp", 32'(ok), 32'd1);
                force dut.l1_stub.d_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("hold_d_valid",  32'(dut.l1_stub.d_valid), 32'd1);
                    chk("hold_d_source", 32'(dut.l1_stub.d_source), 32'd1);
                    chk("hold_a_ready",  32'(dut.l1_stub.a_ready), 32'd0);
                end
                @(posedge clk); #1;
                release dut.l1_stub.d_ready;
            end
            if (tbl[t].mid_rst) begin
                wait_state(S_GET_RESP, ok);
                chk("wait_get_resp", 32'(ok), 32'd1);
                rst_n = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("mid_state",   32'(dut.l1_stub.state_q), S_IDLE);
                chk("mid_a_valid", 32'(dut.l1_stub.a_valid), 32'd0);
                chk("mid_d_valid", 32'(dut.l1_stub.d_valid), 32'd0);
                chk("mid_done",    32'(dut.l1_stub.done), 32'd0);
                chk("mid_mem4",    dut.l2_stub.mem[4], 32'hDEADBEEF);
                @(posedge clk); #1;
                rst_n = 1'b1;
            end

            cyc = 0;
            while (!dut.l1_stub.done && cyc < 30) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk("done_reached", 32'(dut.l1_stub.done), 32'd1);
            if (!tbl[t].hold_dready && !tbl[t].mid_rst)
                chk("done_le10", 32'(cyc <= 10), 32'd1);
            @(negedge clk);
            chk("pass",       32'(dut.l1_stub.pass), 32'(tbl[t].exp_pass));
            chk("a_count",    32'(a_idx), 32'd2);
            chk("sb_empty",   32'(sb.size()), 32'd0);
            chk("mem4",       dut.l2_stub.mem[4], tbl[t].exp4);
            bad = 0;
            for (int i = 0; i < 1024; i++)
                if (i != 4 && dut.l2_stub.mem[i] !== tbl[t].fill) bad++;
            chk("mem_others", 32'(bad), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
